// File: rtl/framebuffer_fill.sv
// Pixel framebuffer: one registered read port, one direct write port and a
// rectangle-fill engine that paints an inclusive box in raster order.
module framebuffer_fill #(
  parameter int unsigned WIDTH      = 640,
  parameter int unsigned HEIGHT     = 480,
  parameter int unsigned COLOR_BITS = 3,
  parameter string       INIT_FILE  = "mif/board.mif",
  localparam int unsigned XW = $clog2(WIDTH),
  localparam int unsigned YW = $clog2(HEIGHT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [XW-1:0]         rd_x,
  input  logic [YW-1:0]         rd_y,
  output logic [COLOR_BITS-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [XW-1:0]         wr_x,
  input  logic [YW-1:0]         wr_y,
  input  logic [COLOR_BITS-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  fill_start,
  input  logic [XW-1:0]         fill_x0,
  input  logic [XW-1:0]         fill_x1,
  input  logic [YW-1:0]         fill_y0,
  input  logic [YW-1:0]         fill_y1,
  input  logic [COLOR_BITS-1:0] fill_color,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic                  fill_error
);

  localparam int unsigned DEPTH = WIDTH * HEIGHT;
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  // INIT_FILE is the preload image handed to the RAM macro flow; the array
  // below is never cleared by reset.
  logic [COLOR_BITS-1:0] mem [DEPTH];

  state_t                state;
  logic [XW-1:0]         cx, x0_q, x1_q;
  logic [YW-1:0]         cy, y1_q;
  logic [COLOR_BITS-1:0] color_q;

  logic                  we_c;
  logic [AW-1:0]         wa_c;
  logic [COLOR_BITS-1:0] wd_c;
  logic                  rd_ok_c, wr_ok_c, cmd_ok_c;

  function automatic logic [AW-1:0] pix_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return AW'(AW'(y) * AW'(WIDTH) + AW'(x));
  endfunction

  assign rd_ok_c  = (32'(rd_x) < WIDTH) && (32'(rd_y) < HEIGHT);
  assign wr_ok_c  = (32'(wr_x) < WIDTH) && (32'(wr_y) < HEIGHT);
  assign cmd_ok_c = (fill_x0 <= fill_x1) && (32'(fill_x1) < WIDTH) &&
                    (fill_y0 <= fill_y1) && (32'(fill_y1) < HEIGHT);

  // Single write port: the fill engine owns it while busy.
  always_comb begin
    we_c = 1'b0;
    wa_c = '0;
    wd_c = '0;
    if (state == FILL) begin
      we_c = 1'b1;
      wa_c = pix_addr(cx, cy);
      wd_c = color_q;
    end else if (wr_en && !fill_busy && wr_ok_c) begin
      we_c = 1'b1;
      wa_c = pix_addr(wr_x, wr_y);
      wd_c = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (we_c) mem[wa_c] <= wd_c;
  end

  // Read sees the array before this edge's write (old data on collision).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_ok_c ? mem[pix_addr(rd_x, rd_y)] : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      fill_busy  <= 1'b0;
      fill_done  <= 1'b0;
      fill_error <= 1'b0;
      wr_ready   <= 1'b1;
      cx         <= '0;
      cy         <= '0;
      x0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      color_q    <= '0;
    end else begin
      fill_done  <= 1'b0;
      fill_error <= 1'b0;
      case (state)
        IDLE: begin
          if (fill_start) begin
            if (cmd_ok_c) begin
              x0_q      <= fill_x0;
              x1_q      <= fill_x1;
              y1_q      <= fill_y1;
              color_q   <= fill_color;
              cx        <= fill_x0;
              cy        <= fill_y0;
              fill_busy <= 1'b1;
              wr_ready  <= 1'b0;
              state     <= FILL;
            end else begin
              fill_error <= 1'b1;
            end
          end
        end
        FILL: begin
          if (cx == x1_q) begin
            cx <= x0_q;
            if (cy == y1_q) begin
              fill_busy <= 1'b0;
              wr_ready  <= 1'b1;
              fill_done <= 1'b1;
              state     <= DONE;
            end else begin
              cy <= cy + 1'b1;
            end
          end else begin
            cx <= cx + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_fill.sv
// Randomised self-checking bench for framebuffer_fill against a pixel-array model.
module tb_framebuffer_fill;

  localparam int W  = 10;
  localparam int H  = 6;
  localparam int CB = 3;
  localparam int XW = 4;
  localparam int YW = 3;

  logic          clk, reset;
  logic          rd_en, wr_en, fill_start;
  logic [XW-1:0] rd_x, wr_x, fill_x0, fill_x1;
  logic [YW-1:0] rd_y, wr_y, fill_y0, fill_y1;
  logic [CB-1:0] rd_data, wr_data, fill_color;
  logic          wr_ready, fill_busy, fill_done, fill_error;

  int total, bad;
  int model [H][W];

  framebuffer_fill #(.WIDTH(W), .HEIGHT(H), .COLOR_BITS(CB)) dut (
    .clk(clk), .reset(reset),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_ready(wr_ready),
    .fill_start(fill_start), .fill_x0(fill_x0), .fill_x1(fill_x1),
    .fill_y0(fill_y0), .fill_y1(fill_y1), .fill_color(fill_color),
    .fill_busy(fill_busy), .fill_done(fill_done), .fill_error(fill_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_en = 0; wr_en = 0; fill_start = 0;
    rd_x = '0; rd_y = '0; wr_x = '0; wr_y = '0; wr_data = '0;
    fill_x0 = '0; fill_x1 = '0; fill_y0 = '0; fill_y1 = '0; fill_color = '0;
  endtask

  task automatic check_status(input string tag, input int busy, input int done, input int err);
    check({tag, "_busy"}, fill_busy, busy);
    check({tag, "_ready"}, wr_ready, !busy);
    check({tag, "_done"}, fill_done, done);
    check({tag, "_err"}, fill_error, err);
  endtask

  function automatic int pix(input int x, input int y);
    return (x < W && y < H) ? model[y][x] : 0;
  endfunction

  task automatic read_px(input int x, input int y, input string tag);
    int e;
    rd_en = 1; rd_x = XW'(x); rd_y = YW'(y);
    e = pix(x, y);
    step();
    rd_en = 0;
    if (e >= 0) check(tag, rd_data, e);
  endtask

  // Direct write with a same-cycle read of the same address, then a read-back.
  task automatic write_px(input int x, input int y, input int c);
    int old;
    wr_en = 1; wr_x = XW'(x); wr_y = YW'(y); wr_data = CB'(c);
    rd_en = 1; rd_x = XW'(x); rd_y = YW'(y);
    old = pix(x, y);
    step();
    wr_en = 0; rd_en = 0;
    if (old >= 0) check("rdw_old", rd_data, old);
    if (x < W && y < H) model[y][x] = c;
    read_px(x, y, "wr_readback");
  endtask

  task automatic readback_all(input string tag);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        read_px(x, y, tag);
  endtask

  // Issue one fill command; abort_at >= 0 asserts reset before pixel abort_at.
  task automatic do_fill(input int x0, input int x1, input int y0, input int y1,
                         input int c, input int abort_at);
    bit valid;
    int w, n, px, py, cwx, cwy, cwd, e;
    bit cw;
    valid = (x0 <= x1) && (x1 < W) && (y0 <= y1) && (y1 < H);
    fill_start = 1; fill_color = CB'(c);
    fill_x0 = XW'(x0); fill_x1 = XW'(x1); fill_y0 = YW'(y0); fill_y1 = YW'(y1);
    cw = 1'($urandom_range(0, 1));
    cwx = $urandom_range(0, W - 1); cwy = $urandom_range(0, H - 1); cwd = $urandom_range(0, 7);
    wr_en = cw; wr_x = XW'(cwx); wr_y = YW'(cwy); wr_data = CB'(cwd);
    step();
    if (cw) model[cwy][cwx] = cwd;
    fill_start = 0; wr_en = 0;
    fill_x0 = XW'($urandom); fill_x1 = XW'($urandom);
    fill_y0 = YW'($urandom); fill_y1 = YW'($urandom); fill_color = CB'($urandom);
    if (!valid) begin
      check_status("reject", 0, 0, 1);
      step();
      check_status("reject_after", 0, 0, 0);
      return;
    end
    check_status("accept", 1, 0, 0);
    w = x1 - x0 + 1;
    n = w * (y1 - y0 + 1);
    for (int k = 0; k < n; k++) begin
      px = x0 + k % w;
      py = y0 + k / w;
      if (k == abort_at) begin
        fill_start = 0; wr_en = 0; rd_en = 0;
        reset = 1;
        #1;
        check_status("abort", 0, 0, 0);
        check("abort_rd", rd_data, 0);
        step();
        step();
        reset = 0;
        for (int j = 0; j < 3; j++) begin
          step();
          check_status("post_abort", 0, 0, 0);
        end
        return;
      end
      // Even k: pixel k reads old (written at this same edge); odd k: pixel k-1 reads new.
      rd_en = 1;
      if (k % 2 == 0) begin
        rd_x = XW'(px); rd_y = YW'(py); e = model[py][px];
      end else begin
        rd_x = XW'(x0 + (k - 1) % w); rd_y = YW'(y0 + (k - 1) / w); e = c;
      end
      // Writes and commands while busy must be ignored.
      wr_en = 1'($urandom_range(0, 1));
      wr_x = XW'($urandom_range(0, W - 1)); wr_y = YW'($urandom_range(0, H - 1));
      wr_data = CB'($urandom);
      fill_start = 1'($urandom_range(0, 1));
      fill_x0 = '0; fill_x1 = XW'(W - 1); fill_y0 = '0; fill_y1 = YW'(H - 1);
      step();
      if (e >= 0) check("fill_order", rd_data, e);
      model[py][px] = c;
      check_status("filling", (k < n - 1) ? 1 : 0, (k == n - 1) ? 1 : 0, 0);
    end
    rd_en = 0; wr_en = 0; fill_start = 0;
    step();
    check_status("fill_end", 0, 0, 0);
  endtask

  initial begin
    int hold;
    total = 0; bad = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        model[y][x] = -1;
    idle_inputs();
    reset = 1;
    step();
    check_status("reset", 0, 0, 0);
    check("reset_rd", rd_data, 0);
    step();
    reset = 0;
    step();
    check_status("idle", 0, 0, 0);

    // Clear the whole buffer so every pixel is known.
    do_fill(0, W - 1, 0, H - 1, 0, -1);
    read_px(0, 0, "rd_origin");
    read_px(W - 1, H - 1, "rd_corner");
    read_px(W, 0, "rd_oob_x");
    read_px(0, H, "rd_oob_y");

    write_px(3, 2, 5);
    write_px(12, 1, 7);        // out of range, aliases (2,2) if not dropped
    read_px(2, 2, "oob_write_dropped");
    write_px(3, 2, 3);

    do_fill(2, 4, 3, 4, 6, -1);
    read_px(1, 3, "fill_edge_left");
    read_px(5, 4, "fill_edge_right");
    do_fill(5, 4, 0, 1, 3, -1);
    do_fill(0, 1, 0, H, 3, -1);
    do_fill(0, W, 0, 1, 3, -1);
    do_fill(1, 1, 2, 1, 3, -1);
    do_fill(7, 7, 1, 1, 2, -1);
    do_fill(0, 2, 0, 2, 7, 3);
    readback_all("directed_readback");

    read_px(7, 1, "hold_setup");
    hold = model[1][7];
    rd_x = '0; rd_y = '0;
    step();
    check("rd_hold", rd_data, hold);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: write_px($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7));
        1: read_px($urandom_range(0, 15), $urandom_range(0, 7), "rand_read");
        default: do_fill($urandom_range(0, 11), $urandom_range(0, 11),
                         $urandom_range(0, 6), $urandom_range(0, 6),
                         $urandom_range(0, 7), ($urandom_range(0, 7) == 0) ? 2 : -1);
      endcase
    end
    readback_all("final_readback");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/framebuffer_fill.md
# framebuffer_fill

Parametrised pixel framebuffer with one registered read port, one direct write port and a built-in rectangle-fill engine. It sits between the game/drawing logic (writer) and the VGA scan-out (reader). It lets the controller clear or paint a cell, cursor or whole board with one command instead of streaming pixels. Geometry and colour depth are parameters, so the same block serves the 640x480 3-bit board and smaller overlay buffers.

## Interface
Parameters:
- WIDTH, 640: pixels per line.
- HEIGHT, 480: lines.
- COLOR_BITS, 3: bits per pixel.
- INIT_FILE, "mif/board.mif": RAM initialisation file.
- Derived: XW = $clog2(WIDTH), YW = $clog2(HEIGHT).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd_en  in  1  read request.
- rd_x  in  XW  read pixel column.
- rd_y  in  YW  read line.
- rd_data  out  COLOR_BITS  registered read data.
- wr_en  in  1  direct write request.
- wr_x  in  XW  write pixel column.
- wr_y  in  YW  write line.
- wr_data  in  COLOR_BITS  write colour.
- wr_ready  out  1  direct writes accepted (= !fill_busy).
- fill_start  in  1  fill command strobe.
- fill_x0, fill_x1  in  XW  inclusive column bounds.
- fill_y0, fill_y1  in  YW  inclusive line bounds.
- fill_color  in  COLOR_BITS  fill colour.
- fill_busy  out  1  fill in progress.
- fill_done  out  1  one-cycle pulse when a fill completes.
- fill_error  out  1  one-cycle pulse when a fill command is rejected.

## Operation
- Storage: WIDTH*HEIGHT words of COLOR_BITS bits, initialised from INIT_FILE. Contents are never cleared by reset.
- Read: if rd_en, rd_data <= mem[rd_y][rd_x]. If rd_x >= WIDTH or rd_y >= HEIGHT, rd_data <= 0. Without rd_en, rd_data holds its value.
- Read-during-write to the same address returns the old data.
- Direct write: performed when wr_en && !fill_busy and the coordinates are in range. An out-of-range write is silently dropped. While fill_busy, wr_en is ignored and the write is lost; the caller must check wr_ready.
- Fill FSM states: IDLE, FILL, DONE.
  - IDLE + fill_start:
    - Valid when fill_x0 <= fill_x1 < WIDTH and fill_y0 <= fill_y1 < HEIGHT. On a valid command, latch the bounds and colour, set cx = x0 and cy = y0, and go to FILL.
    - Otherwise pulse fill_error and stay in IDLE.
  - FILL: each cycle write fill_color at (cx, cy), in raster order:
    - cx++ while cx < x1.
    - At cx == x1: cx = x0 and cy++.
    - At (x1, y1): go to DONE.
  - DONE: fill_done = 1 for one cycle, then return to IDLE.
- fill_start is ignored outside IDLE. Command inputs need only be valid in the cycle fill_start is high.
- A direct write and an accepted fill_start in the same cycle: the direct write commits, and the fill begins the next cycle.
- Pixel count arithmetic: N = (x1-x0+1)*(y1-y0+1). Counters are XW/YW bits wide and compare with ==, so they never overflow past the bounds. A single-pixel fill (x0 = x1, y0 = y1) gives N = 1.

## Timing
- Read latency: 1 cycle. Request at edge T, data valid after edge T+1.
- Direct write visible to a read issued in the cycle after the write.
- Fill accepted at edge T:
  - fill_busy = 1 for cycles T+1..T+N.
  - Pixel k (0-based, raster order) is written at edge T+1+k.
  - fill_done = 1 and fill_busy = 0 in cycle T+N+1.
  - wr_ready = 0 for exactly N cycles.
- Rejected fill at edge T: fill_error = 1 in cycle T+1 only, no writes, and fill_busy stays 0.
- Back-to-back fills: the earliest next acceptance is in the fill_done cycle + 1 (IDLE).
- Reset values: rd_data = 0, fill_busy = 0, fill_done = 0, fill_error = 0, wr_ready = 1, FSM = IDLE.
- Reset mid-fill: the fill aborts immediately. Pixels already written remain, no fill_done is issued, and the block accepts commands after reset deasserts.

## Test plan
- After reset, read (0,0) and (639,479) -> rd_data matches INIT_FILE one cycle later. Read (640,0) -> 0.
- Write colour 5 at (10,20), then read (10,20) next cycle -> 5. Same-cycle read of (10,20) -> old value.
- Fill (2,3)-(4,4) with colour 6 -> fill_busy high for exactly 6 cycles, and the writes occur in order (2,3),(3,3),(4,3),(2,4),(3,4),(4,4). fill_done is 1 for one cycle at T+7, and (1,3) and (5,4) are unchanged.
- Fill with x0=5, x1=4, and separately y1=480 -> fill_error pulse, no busy, memory unchanged.
- wr_en at (0,0) with colour 1 during a busy fill -> wr_ready = 0 and the pixel is unchanged. fill_start during busy -> ignored, and the first fill completes normally.
- Assert reset at pixel 3 of a 9-pixel fill -> outputs go to their reset values, pixels 0-2 are written, pixels 3-8 are unchanged, and no fill_done is issued.
